// File: rtl/serial_deser_pkg.sv
// deser_pkg: shared state encoding and sizing helpers for the serial receive stage
package deser_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, DATA = 2'b01, STOP = 2'b10} state_t;
  localparam int DEFAULT_WIDTH = 8;
  function automatic int cntWidth(input int w);
    return w < 2 ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_deser_if.sv
// serial_deser_if: serial input, bit strobe and parallel valid/ready bundle
interface serial_deser_if import deser_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
  logic D_IN, EN, DREADY, DVALID, BUSY, FERR, OVERRUN;
  logic [WIDTH-1:0] DOUT;
  modport master(output D_IN, EN, DREADY, input DOUT, DVALID, BUSY, FERR, OVERRUN);
  modport slave(input D_IN, EN, DREADY, output DOUT, DVALID, BUSY, FERR, OVERRUN);
endinterface

// File: rtl/shift_reg_sipo.sv
// shift_reg_sipo: right-shifting serial-in parallel-out register, new bit enters the MSB
module shift_reg_sipo #(parameter int WIDTH = 8) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             shiftEn,
  input  logic             serialIn,
  output logic [WIDTH-1:0] parOut
);
  always_ff @(posedge CLK)
    parOut <= RST ? '0 : shiftEn ? {serialIn, parOut[WIDTH-1:1]} : parOut;
endmodule

// File: rtl/serial_deser.sv
// serial_deser: start/stop framed serial receiver with valid/ready output, framing and overrun flags
module serial_deser import deser_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input logic CLK,
  input logic RST,
  serial_deser_if.slave bus
);
  localparam int CW = cntWidth(WIDTH);
  state_t state, nextState;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] shiftQ;
  logic stopEn, goodStop, load;
  assign stopEn = state == STOP && bus.EN;
  assign goodStop = stopEn && bus.D_IN;
  // a good word is only dropped when the previous one is still held and not taken this cycle
  assign load = goodStop && !(bus.DVALID && !bus.DREADY);
  assign bus.BUSY = state == DATA || state == STOP;
  shift_reg_sipo #(.WIDTH(WIDTH)) sipo (
    .CLK(CLK), .RST(RST), .shiftEn(state == DATA && bus.EN), .serialIn(bus.D_IN), .parOut(shiftQ)
  );
  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE: nextState = bus.EN && !bus.D_IN ? DATA : IDLE;
      DATA: nextState = bus.EN && cnt == CW'(WIDTH - 1) ? STOP : DATA;
      STOP: nextState = bus.EN ? IDLE : STOP;
      default: nextState = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      bus.DOUT <= '0;
      bus.DVALID <= 1'b0;
      bus.FERR <= 1'b0;
      bus.OVERRUN <= 1'b0;
    end else begin
      state <= nextState;
      cnt <= state == IDLE ? '0 : (state == DATA && bus.EN) ? cnt + CW'(1) : cnt;
      bus.FERR <= stopEn && !bus.D_IN;
      bus.OVERRUN <= bus.OVERRUN || (goodStop && !load);
      bus.DVALID <= load || (bus.DVALID && !bus.DREADY);
      if (load) bus.DOUT <= shiftQ;
    end
  end
endmodule
